gadget: RTL and testbench
=========================

# gadget

Power-up (gadget) manager for the 16x16 two-player bomb game. Holds per-tile gadget state, reveals hidden gadgets when an explosion covers them, awards collected gadgets to players, and drives each player's bomb capacity and blast length. Sits between the wall/bomb logic (explosion map) and the keyboard controller, bomb unit and display (capacity, length, tile grid).

## Interface
- No parameters.
- clk  in  1  game clock (30 Hz tick domain).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  game running; level-sensitive.
- gadget_type  in  2  layout select, sampled while idle.
- p1_cor, p2_cor  in  8 each  player tile index {y[3:0], x[3:0]}.
- i_explode  in  256  bit i set = tile i in blast this cycle.
- o_p1_cap, o_p2_cap  out  3 each  bomb capacity.
- o_p1_len, o_p2_len  out  2 each  blast length.
- gadget_grid  out  3 x [0:255]  per-tile code.
- p2_able_to_add_bomb  out  1  debug: o_p2_cap < 7.

## Operation
- Tile codes: 0 empty, 1 hidden cap, 2 hidden len, 3 visible cap, 4 visible len; 5-7 never produced.
- States: IDLE, PLAY. Reset -> IDLE. IDLE with start=1 -> PLAY. PLAY with start=0 -> IDLE.
- IDLE, every clock: grid loaded from layout; caps=1, lens=1.
- Layouts (x = idx[3:0], y = idx[7:4]):
  - type 0: code 1 if x%4==2 && y%4==2; code 2 if x%4==2 && y%4==0; else 0.
  - type 1: roles of codes 1 and 2 swapped versus type 0.
  - type 2: code 1 if x and y both odd; else 0.
  - type 3: all 0.
- PLAY, per tile per clock, in priority order:
  - Collect: visible tile (3/4) where p1_cor==i or p2_cor==i -> tile 0; P1 wins if both players are on it.
    - Code 3 increments the collector's cap, saturating at 7.
    - Code 4 increments the collector's len, saturating at 3.
  - Else explode bit set: hidden 1->3, 2->4; visible 3/4 -> 0 (destroyed); 0 stays 0.
  - Else hold.
- A player collects at most one tile per clock (only the tile at its own coordinate).
- Same tile revealed and stood on in the same cycle: reveal only; collection possible from the next cycle.

## Timing
- All outputs registered; 1-cycle latency from inputs.
- Reset values: o_p1_cap = o_p2_cap = 1; o_p1_len = o_p2_len = 1; grid all 0; p2_able_to_add_bomb = 1 when GADGET_DEBUG_EN is defined, else 0.
- Reset mid-game: immediate return to the reset values; layout reloads on the first IDLE clock.
- start falling mid-game: the next clock is IDLE; layout reloads and caps/lens return to 1.

## Configuration
- GADGET_DEBUG_EN:
  - Defined: p2_able_to_add_bomb = (o_p2_cap != 7), registered with the cap.
  - Undefined: p2_able_to_add_bomb tied 0.
- All other behaviour is identical in both builds.

## Test plan
- Reset then one IDLE clock with gadget_type=0:
  - caps 1, lens 1.
  - grid[0x22]=1, grid[0x02]=2, grid[0x00]=0.
  - With gadget_type=3 instead: grid all 0.
- Reveal and collect:
  - start=1, i_explode bit 0x22 for one cycle -> grid[0x22]=3.
  - Then p1_cor=0x22 -> next cycle o_p1_cap=2, grid[0x22]=0.
- Destroy: visible tile 0x02 (code 4), no player on it, explode bit 0x02 -> grid[0x02]=0; lens unchanged.
- Tie on one tile: p1_cor=p2_cor on a visible cap tile -> o_p1_cap +1; o_p2_cap unchanged; tile 0.
- Saturation:
  - P2 collects 7 cap gadgets -> o_p2_cap stops at 7; p2_able_to_add_bomb=0 (debug build).
  - Four len gadgets -> len stops at 3.
- Restart: start dropped with caps=4 -> next clock caps=1 and layout restored; asserting rst mid-PLAY clears the grid immediately.

Source files
------------

// File: rtl/gadget.sv
// Power-up manager for the 16x16 bomb game: per-tile gadget state, reveal on explosion, collection into player cap/len.
// Latency: every output is registered, one clock from inputs; rst clears state asynchronously.
// Backpressure: none, all inputs are consumed every clock. GADGET_DEBUG_EN enables p2_able_to_add_bomb (else tied 0).
module gadget (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   gadget_type,
    input  logic [7:0]   p1_cor,
    input  logic [7:0]   p2_cor,
    input  logic [255:0] i_explode,
    output logic [2:0]   o_p1_cap,
    output logic [2:0]   o_p2_cap,
    output logic [1:0]   o_p1_len,
    output logic [1:0]   o_p2_len,
    output logic [2:0]   gadget_grid [0:255],
    output logic         p2_able_to_add_bomb
);

    localparam logic [2:0] C_EMPTY = 3'd0;
    localparam logic [2:0] C_HCAP  = 3'd1;
    localparam logic [2:0] C_HLEN  = 3'd2;
    localparam logic [2:0] C_VCAP  = 3'd3;
    localparam logic [2:0] C_VLEN  = 3'd4;

    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [2:0] grid_q [0:255];
    logic [2:0] grid_d [0:255];
    logic [2:0] p1_cap_q, p1_cap_d, p2_cap_q, p2_cap_d;
    logic [1:0] p1_len_q, p1_len_d, p2_len_q, p2_len_d;
    logic       play_active;
    logic       p1_take, p2_take;
    logic [2:0] p1_code, p2_code;

    // Starting gadget placement; x = idx[3:0], y = idx[7:4], so x%4 = idx[1:0], y%4 = idx[5:4]
    function automatic logic [2:0] layout_code(input logic [1:0] t, input logic [7:0] idx);
        logic [2:0] code;
        code = C_EMPTY;
        case (t)
            2'd0: if (idx[1:0] == 2'd2) begin
                      if (idx[5:4] == 2'd2)      code = C_HCAP;
                      else if (idx[5:4] == 2'd0) code = C_HLEN;
                  end
            2'd1: if (idx[1:0] == 2'd2) begin
                      if (idx[5:4] == 2'd2)      code = C_HLEN;
                      else if (idx[5:4] == 2'd0) code = C_HCAP;
                  end
            2'd2: if (idx[0] && idx[4]) code = C_HCAP;
            default: code = C_EMPTY;
        endcase
        return code;
    endfunction

    // Next state, per-tile update and player counters
    always_comb begin
        state_d  = state_q;
        grid_d   = grid_q;
        p1_cap_d = p1_cap_q;
        p2_cap_d = p2_cap_q;
        p1_len_d = p1_len_q;
        p2_len_d = p2_len_q;

        case (state_q)
            IDLE:    if (start)  state_d = PLAY;
            PLAY:    if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Dropping start in PLAY behaves like IDLE on that same clock so the
        // layout and counters are restored on the very next edge.
        play_active = (state_q == PLAY) && start;

        // Each player can only pick up the tile under it; P1 wins a shared tile.
        p1_code = grid_q[p1_cor];
        p2_code = grid_q[p2_cor];
        p1_take = (p1_code == C_VCAP) || (p1_code == C_VLEN);
        p2_take = ((p2_code == C_VCAP) || (p2_code == C_VLEN)) && (p2_cor != p1_cor);

        if (play_active) begin
            for (int i = 0; i < 256; i++) begin
                if (((grid_q[i] == C_VCAP) || (grid_q[i] == C_VLEN)) &&
                    ((p1_cor == 8'(i)) || (p2_cor == 8'(i)))) begin
                    grid_d[i] = C_EMPTY;
                end else if (i_explode[i]) begin
                    case (grid_q[i])
                        C_HCAP:          grid_d[i] = C_VCAP;
                        C_HLEN:          grid_d[i] = C_VLEN;
                        C_VCAP, C_VLEN:  grid_d[i] = C_EMPTY;
                        default:         grid_d[i] = grid_q[i];
                    endcase
                end
            end

            if (p1_take && (p1_code == C_VCAP) && (p1_cap_q != 3'd7)) p1_cap_d = p1_cap_q + 3'd1;
            if (p1_take && (p1_code == C_VLEN) && (p1_len_q != 2'd3)) p1_len_d = p1_len_q + 2'd1;
            if (p2_take && (p2_code == C_VCAP) && (p2_cap_q != 3'd7)) p2_cap_d = p2_cap_q + 3'd1;
            if (p2_take && (p2_code == C_VLEN) && (p2_len_q != 2'd3)) p2_len_d = p2_len_q + 2'd1;
        end else begin
            for (int i = 0; i < 256; i++) begin
                grid_d[i] = layout_code(gadget_type, 8'(i));
            end
            p1_cap_d = 3'd1;
            p2_cap_d = 3'd1;
            p1_len_d = 2'd1;
            p2_len_d = 2'd1;
        end
    end

    // State, grid and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            p1_cap_q <= 3'd1;
            p2_cap_q <= 3'd1;
            p1_len_q <= 2'd1;
            p2_len_q <= 2'd1;
            for (int i = 0; i < 256; i++) grid_q[i] <= C_EMPTY;
        end else begin
            state_q  <= state_d;
            p1_cap_q <= p1_cap_d;
            p2_cap_q <= p2_cap_d;
            p1_len_q <= p1_len_d;
            p2_len_q <= p2_len_d;
            for (int i = 0; i < 256; i++) grid_q[i] <= grid_d[i];
        end
    end

    assign o_p1_cap    = p1_cap_q;
    assign o_p2_cap    = p2_cap_q;
    assign o_p1_len    = p1_len_q;
    assign o_p2_len    = p2_len_q;
    assign gadget_grid = grid_q;

`ifdef GADGET_DEBUG_EN
    logic dbg_q, dbg_d;

    // Debug flag tracks the next P2 cap so it lines up with o_p2_cap
    always_comb begin
        dbg_d = (p2_cap_d != 3'd7);
    end

    // Debug flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dbg_q <= 1'b1;
        else     dbg_q <= dbg_d;
    end

    assign p2_able_to_add_bomb = dbg_q;
`else
    assign p2_able_to_add_bomb = 1'b0;
`endif

endmodule

// File: tb/tb_gadget.sv
// Bench for gadget: directed walk through reveal/collect/destroy/saturation/restart, then random play.
// Reference model works on plain integer tile codes and counters derived from the game rules.
// All outputs are compared 1 time unit after each rising edge.
module tb_gadget;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   gadget_type;
    logic [7:0]   p1_cor, p2_cor;
    logic [255:0] i_explode;
    logic [2:0]   o_p1_cap, o_p2_cap;
    logic [1:0]   o_p1_len, o_p2_len;
    logic [2:0]   gadget_grid [0:255];
    logic         p2_able_to_add_bomb;

    int checks = 0;
    int errors = 0;

    int m_grid [256];
    int m_cap  [2];
    int m_len  [2];
    bit m_running;

    gadget dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .gadget_type         (gadget_type),
        .p1_cor              (p1_cor),
        .p2_cor              (p2_cor),
        .i_explode           (i_explode),
        .o_p1_cap            (o_p1_cap),
        .o_p2_cap            (o_p2_cap),
        .o_p1_len            (o_p1_len),
        .o_p2_len            (o_p2_len),
        .gadget_grid         (gadget_grid),
        .p2_able_to_add_bomb (p2_able_to_add_bomb)
    );

    always #5 clk = ~clk;

    function automatic int layout(int t, int idx);
        int x = idx % 16;
        int y = idx / 16;
        if (t == 0) begin
            if (x % 4 == 2 && y % 4 == 2) return 1;
            if (x % 4 == 2 && y % 4 == 0) return 2;
            return 0;
        end else if (t == 1) begin
            if (x % 4 == 2 && y % 4 == 2) return 2;
            if (x % 4 == 2 && y % 4 == 0) return 1;
            return 0;
        end else if (t == 2) begin
            return (x % 2 == 1 && y % 2 == 1) ? 1 : 0;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [767:0] dut_grid_packed();
        logic [767:0] v = '0;
        for (int i = 0; i < 256; i++) v[3*i +: 3] = gadget_grid[i];
        return v;
    endfunction

    function automatic logic [767:0] model_grid_packed();
        logic [767:0] v = '0;
        for (int i = 0; i < 256; i++) v[3*i +: 3] = 3'(m_grid[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_grid[i] = 0;
        m_cap[0] = 1; m_cap[1] = 1;
        m_len[0] = 1; m_len[1] = 1;
        m_running = 1'b0;
    endtask

    // One clock of game rules applied to the currently driven inputs
    task automatic model_step();
        int  ng [256];
        int  a, b;
        bit  t1, t2;
        if (!(m_running && start)) begin
            for (int i = 0; i < 256; i++) ng[i] = layout(int'(gadget_type), i);
            m_cap[0] = 1; m_cap[1] = 1;
            m_len[0] = 1; m_len[1] = 1;
        end else begin
            a  = int'(p1_cor);
            b  = int'(p2_cor);
            t1 = (m_grid[a] >= 3);
            t2 = (m_grid[b] >= 3) && (a != b);
            for (int i = 0; i < 256; i++) begin
                ng[i] = m_grid[i];
                if ((t1 && i == a) || (t2 && i == b)) ng[i] = 0;
                else if (i_explode[i]) begin
                    if (m_grid[i] == 1)      ng[i] = 3;
                    else if (m_grid[i] == 2) ng[i] = 4;
                    else                     ng[i] = 0;
                end
            end
            if (t1) begin
                if (m_grid[a] == 3) m_cap[0] = (m_cap[0] < 7) ? m_cap[0] + 1 : 7;
                else                m_len[0] = (m_len[0] < 3) ? m_len[0] + 1 : 3;
            end
            if (t2) begin
                if (m_grid[b] == 3) m_cap[1] = (m_cap[1] < 7) ? m_cap[1] + 1 : 7;
                else                m_len[1] = (m_len[1] < 3) ? m_len[1] + 1 : 3;
            end
        end
        for (int i = 0; i < 256; i++) m_grid[i] = ng[i];
        m_running = start;
    endtask

    task automatic check_all(input string ctx);
        logic exp_dbg;
`ifdef GADGET_DEBUG_EN
        exp_dbg = (m_cap[1] != 7);
`else
        exp_dbg = 1'b0;
`endif
        check({ctx, ".p1_cap"}, 768'(o_p1_cap), 768'(m_cap[0]));
        check({ctx, ".p2_cap"}, 768'(o_p2_cap), 768'(m_cap[1]));
        check({ctx, ".p1_len"}, 768'(o_p1_len), 768'(m_len[0]));
        check({ctx, ".p2_len"}, 768'(o_p2_len), 768'(m_len[1]));
        check({ctx, ".dbg"},    768'(p2_able_to_add_bomb), 768'(exp_dbg));
        check({ctx, ".grid"},   dut_grid_packed(), model_grid_packed());
    endtask

    task automatic tick(input string ctx);
        model_step();
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    // Called 1 time unit after an edge: pulse reset asynchronously, check, release
    task automatic async_reset(input string ctx);
        rst = 1'b1;
        #2;
        model_reset();
        check_all(ctx);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] pick_cor();
        int q[$];
        for (int i = 0; i < 256; i++) if (m_grid[i] >= 3) q.push_back(i);
        if (q.size() > 0 && $urandom_range(0, 1) == 1) return 8'(q[$urandom_range(0, q.size() - 1)]);
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int idx;
        rst         = 1'b1;
        start       = 1'b0;
        gadget_type = 2'd0;
        p1_cor      = 8'hFF;
        p2_cor      = 8'hFF;
        i_explode   = '0;
        model_reset();
        #3;
        check_all("reset");
        rst = 1'b0;

        // Idle layouts
        tick("idle_t0");
        check("idle_g22", 768'(gadget_grid[8'h22]), 768'd1);
        check("idle_g02", 768'(gadget_grid[8'h02]), 768'd2);
        check("idle_g00", 768'(gadget_grid[8'h00]), 768'd0);
        check("idle_cap", 768'(o_p1_cap), 768'd1);
        gadget_type = 2'd3;
        tick("idle_t3");
        check("idle_t3_empty", dut_grid_packed(), 768'd0);
        gadget_type = 2'd0;
        tick("idle_t0b");

        // Enter play, reveal and collect
        start = 1'b1;
        tick("enter_play");
        i_explode[8'h22] = 1'b1;
        tick("reveal22");
        check("reveal_g22", 768'(gadget_grid[8'h22]), 768'd3);
        i_explode = '0;
        p1_cor = 8'h22;
        tick("collect22");
        check("collect_cap", 768'(o_p1_cap), 768'd2);
        check("collect_g22", 768'(gadget_grid[8'h22]), 768'd0);
        p1_cor = 8'hFF;

        // Reveal then destroy a len gadget
        i_explode[8'h02] = 1'b1;
        tick("reveal02");
        check("reveal_g02", 768'(gadget_grid[8'h02]), 768'd4);
        tick("destroy02");
        check("destroy_g02", 768'(gadget_grid[8'h02]), 768'd0);
        check("destroy_len", 768'(o_p1_len), 768'd1);
        i_explode = '0;

        // Both players on one visible cap tile
        i_explode[8'h26] = 1'b1;
        tick("reveal26");
        i_explode = '0;
        p1_cor = 8'h26;
        p2_cor = 8'h26;
        tick("tie26");
        check("tie_p1_cap", 768'(o_p1_cap), 768'd3);
        check("tie_p2_cap", 768'(o_p2_cap), 768'd1);
        check("tie_g26", 768'(gadget_grid[8'h26]), 768'd0);
        p1_cor = 8'hFF;
        p2_cor = 8'hFF;

        // Reveal every cap and len tile, then P2 collects seven caps
        for (int i = 0; i < 256; i++) i_explode[i] = ((i % 16) % 4 == 2) && ((i / 16) % 2 == 0);
        tick("reveal_all");
        i_explode = '0;
        for (int k = 0; k < 7; k++) begin
            idx = (k < 4) ? (16 * 10 + 2 + 4 * k) : (16 * 14 + 2 + 4 * (k - 4));
            p2_cor = 8'(idx);
            tick("p2_cap_walk");
        end
        check("sat_p2_cap", 768'(o_p2_cap), 768'd7);
`ifdef GADGET_DEBUG_EN
        check("sat_dbg", 768'(p2_able_to_add_bomb), 768'd0);
`endif
        p2_cor = 8'hFF;

        // P1 collects four len gadgets
        for (int k = 0; k < 4; k++) begin
            p1_cor = 8'(16 * 4 + 2 + 4 * k);
            tick("p1_len_walk");
        end
        check("sat_p1_len", 768'(o_p1_len), 768'd3);
        p1_cor = 8'h62;
        tick("p1_cap4");
        check("p1_cap4", 768'(o_p1_cap), 768'd4);
        p1_cor = 8'hFF;

        // Drop start: immediate restore
        start = 1'b0;
        tick("restart");
        check("restart_cap", 768'(o_p1_cap), 768'd1);
        check("restart_g22", 768'(gadget_grid[8'h22]), 768'd1);

        // Reset in the middle of play
        start = 1'b1;
        tick("replay");
        i_explode = '1;
        tick("replay_boom");
        i_explode = '0;
        async_reset("mid_reset");
        check("mid_reset_grid", dut_grid_packed(), 768'd0);

        // Random play
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 39) == 0) gadget_type = 2'($urandom_range(0, 3));
            start = ($urandom_range(0, 39) != 0);
            for (int i = 0; i < 256; i++) i_explode[i] = ($urandom_range(0, 11) == 0);
            p1_cor = pick_cor();
            p2_cor = ($urandom_range(0, 7) == 0) ? p1_cor : pick_cor();
            if ($urandom_range(0, 199) == 0) async_reset("rand_reset");
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
